activation_interp: RTL and testbench

//  Consumer side of the per-layer activation LUT (func<n> my_lut).
//  - Takes a signed fixed-point pre-activation x.
//  - Drives the LUT address, reads back the base and next__data samples.
//  - Outputs the piecewise-linear interpolation base + (next - base)*frac / 2^FRAC_W.
//  - Sits between each neuron accumulator and the next layer input; valid/ready on both sides.

---
 rtl/activation_interp.sv | 123 ++++++++++++
 tb/tb_activation_interp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/activation_interp.sv
// Piecewise-linear activation interpolator: drives the LUT segment address,
// captures the base/next samples and blends them by the fractional bits of x.
// Three-stage valid/ready pipeline with one common stage enable.
module activation_interp #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [ADDR_W+FRAC_W-1:0] i_in_data,
  output logic [ADDR_W-1:0]        o_address,
  input  logic [DATA_W-1:0]        i_base,
  input  logic [DATA_W-1:0]        i_next__data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DATA_W-1:0]        o_out_data
);

  localparam int unsigned IN_W   = ADDR_W + FRAC_W;
  localparam int unsigned DIFF_W = DATA_W + 1;
  localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;

  logic                     r_s1_v;
  logic [ADDR_W-1:0]        r_s1_seg;
  logic [FRAC_W-1:0]        r_s1_frac;
  logic                     r_s2_v;
  logic signed [DATA_W-1:0] r_s2_base;
  logic [FRAC_W-1:0]        r_s2_frac;
  logic signed [DIFF_W-1:0] r_s2_diff;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_data;

  logic                     w_en;
  logic signed [DIFF_W-1:0] w_diff;
  logic signed [PROD_W-1:0] w_base_x;
  logic signed [PROD_W-1:0] w_diff_x;
  logic signed [PROD_W-1:0] w_frac_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_acc;
  logic signed [PROD_W-1:0] w_next_x;
  logic signed [PROD_W-1:0] w_lo;
  logic signed [PROD_W-1:0] w_hi;
  logic signed [PROD_W-1:0] w_lo_s;
  logic signed [PROD_W-1:0] w_hi_s;

  // Common pipeline enable; a stalled output freezes every stage.
  assign w_en        = !r_out_valid || i_out_ready;
  assign o_in_ready  = w_en;
  assign o_address   = r_s1_seg;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

  // Slope between adjacent LUT samples, one bit wider so it cannot overflow.
  assign w_diff = DIFF_W'($signed(i_next__data)) - DIFF_W'($signed(i_base));

  // Blend in base*2^FRAC_W units; the top DATA_W bits above the fraction are the
  // floored result, which is also the truncated (DATA_W+1)-bit sum.
  always_comb begin
    w_base_x = PROD_W'(r_s2_base);
    w_diff_x = PROD_W'(r_s2_diff);
    w_frac_x = PROD_W'({1'b0, r_s2_frac});
    w_prod   = w_diff_x * w_frac_x;
    w_acc    = (w_base_x <<< FRAC_W) + w_prod;
    w_next_x = w_base_x + w_diff_x;
    w_lo     = (w_next_x < w_base_x) ? w_next_x : w_base_x;
    w_hi     = (w_next_x < w_base_x) ? w_base_x : w_next_x;
    w_lo_s   = w_lo <<< FRAC_W;
    w_hi_s   = (w_hi + PROD_W'(1)) <<< FRAC_W;
  end

  // Stage 1: split x into segment index (LUT address) and fraction.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1_v    <= 1'b0;
      r_s1_seg  <= '0;
      r_s1_frac <= '0;
    end else if (w_en) begin
      r_s1_v    <= i_in_valid;
      r_s1_seg  <= i_in_data[IN_W-1:FRAC_W];
      r_s1_frac <= i_in_data[FRAC_W-1:0];
    end
  end

  // Stage 2: capture the LUT samples as base and slope.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s2_v    <= 1'b0;
      r_s2_base <= '0;
      r_s2_frac <= '0;
      r_s2_diff <= '0;
    end else if (w_en) begin
      r_s2_v    <= r_s1_v;
      r_s2_base <= $signed(i_base);
      r_s2_frac <= r_s1_frac;
      r_s2_diff <= w_diff;
    end
  end

  // Stage 3: output register; data only moves on a valid item so bubbles stay hidden.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s2_v;
      if (r_s2_v) begin
        r_out_data <= w_acc[FRAC_W +: DATA_W];
      end
    end
  end

  // Interpolated value must stay between the two samples, so truncation is lossless.
  always @(posedge i_clk) begin
    if (i_rst && w_en && r_s2_v) begin
      assert ((w_acc >= w_lo_s) && (w_acc < w_hi_s))
        else $error("interpolation result outside [base,next] range");
    end
  end

endmodule

// File: tb/tb_activation_interp.sv
// Directed bench for activation_interp with a behavioural LUT attached.
module tb_activation_interp;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_data;
  logic [3:0] o_address;
  logic [7:0] i_base;
  logic [7:0] i_next__data;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [7:0] o_out_data;

  int checks = 0;
  int failures = 0;

  logic signed [7:0] lut [16];
  logic [3:0]        w_nidx;

  always #5 i_clk = ~i_clk;

  activation_interp #(.ADDR_W(4), .FRAC_W(4), .DATA_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .o_address    (o_address),
    .i_base       (i_base),
    .i_next__data (i_next__data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data)
  );

  // LUT model: clamps at the top positive segment, wraps all-ones to 0.
  always_comb begin
    w_nidx       = (o_address == 4'd7) ? 4'd7 : o_address + 4'd1;
    i_base       = lut[o_address];
    i_next__data = lut[w_nidx];
  end

  typedef struct {
    logic [7:0] x;
    logic [7:0] exp;
    bit         alt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_lut(input bit alt);
    for (int k = 0; k < 16; k++) lut[k] = (k < 8) ? 8'(16 * k) : 8'sd0;
    if (alt) begin
      lut[1] = 8'sd10;
      lut[2] = 8'sd3;
    end
  endtask

  // Reference: base + floor((next-base)*frac/16), truncated to 8 bits.
  function automatic logic [7:0] ref_f(input logic [7:0] x);
    int seg, nx, b, n, f, q;
    seg = int'(x[7:4]);
    nx  = (seg == 7) ? 7 : (seg + 1) % 16;
    b   = int'(lut[seg]);
    n   = int'(lut[nx]);
    f   = int'(x[3:0]);
    q   = ((n - b) * f) >>> 4;
    return 8'(b + q);
  endfunction

  // Single item with out_ready held high: checks 3-cycle latency and value.
  task automatic apply_vec(input logic [7:0] x, input logic [7:0] exp, input int id);
    int cyc;
    i_in_data   = x;
    i_in_valid  = 1'b1;
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    cyc = 1;
    while (!o_out_valid && cyc < 10) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    chk($sformatf("latency vec%0d", id), cyc, 3);
    chk($sformatf("data vec%0d", id), int'(o_out_data), int'(exp));
    @(posedge i_clk); #1;
  endtask

  // Streams x=0..n-1; checks order, values, handshake and stall stability.
  task automatic run_stream(input int n, input bit rnd, input string tag);
    logic [7:0] q[$];
    logic [7:0] held;
    logic [7:0] e;
    int sent, got, cyc, first, last;
    bit stalled;
    sent = 0; got = 0; cyc = 0; first = -1; last = 0; stalled = 1'b0; held = '0;
    while (got < n && cyc < 4000) begin
      i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_in_valid  = (sent < n);
      i_in_data   = 8'(sent);
      #1;
      chk({tag, " in_ready"}, int'(o_in_ready), int'(!o_out_valid || i_out_ready));
      if (stalled) chk({tag, " stall hold"}, int'(o_out_data), int'(held));
      if (o_out_valid && i_out_ready) begin
        if (q.size() == 0) begin
          chk({tag, " extra output"}, 1, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("%s out#%0d", tag, got), int'(o_out_data), int'(e));
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      stalled = o_out_valid && !i_out_ready;
      held    = o_out_data;
      if (i_in_valid && o_in_ready) begin
        q.push_back(ref_f(8'(sent)));
        sent++;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    chk({tag, " output count"}, got, n);
    if (!rnd) chk({tag, " consecutive span"}, last - first, n - 1);
  endtask

  initial begin
    vecs[0]  = '{8'h25, 8'd37,  1'b0};
    vecs[1]  = '{8'h7F, 8'd112, 1'b0};
    vecs[2]  = '{8'hF8, 8'd0,   1'b0};
    vecs[3]  = '{8'h18, 8'd24,  1'b0};
    vecs[4]  = '{8'h30, 8'd48,  1'b0};
    vecs[5]  = '{8'h00, 8'd0,   1'b0};
    vecs[6]  = '{8'h0F, 8'd15,  1'b0};
    vecs[7]  = '{8'h6F, 8'd111, 1'b0};
    vecs[8]  = '{8'h20, 8'd32,  1'b0};
    vecs[9]  = '{8'h11, 8'd9,   1'b1};
    vecs[10] = '{8'h1F, 8'd3,   1'b1};

    set_lut(1'b0);
    i_rst       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b1;
    #12;
    chk("reset out_valid", int'(o_out_valid), 0);
    chk("reset out_data", int'(o_out_data), 0);
    chk("reset address", int'(o_address), 0);
    chk("reset in_ready", int'(o_in_ready), 1);
    #1 i_rst = 1'b1;
    @(posedge i_clk); #1;

    for (int v = 0; v < 11; v++) begin
      set_lut(vecs[v].alt);
      apply_vec(vecs[v].x, vecs[v].exp, v);
    end

    set_lut(1'b1);
    run_stream(256, 1'b0, "alt sweep");
    set_lut(1'b0);
    run_stream(256, 1'b0, "stream");
    run_stream(200, 1'b1, "random ready");

    // Reset with three items in flight.
    i_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_in_valid = 1'b1;
      i_in_data  = (k == 0) ? 8'h25 : ((k == 1) ? 8'h30 : 8'h18);
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0;
    chk("pre-reset out_valid", int'(o_out_valid), 1);
    #2 i_rst = 1'b0;
    #1;
    chk("async reset out_valid", int'(o_out_valid), 0);
    chk("async reset out_data", int'(o_out_data), 0);
    chk("async reset address", int'(o_address), 0);
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      chk("no stale out_valid", int'(o_out_valid), 0);
    end
    apply_vec(8'h25, 8'd37, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
